// File: rtl/div_iter_unit_if.sv
// rtl/div_iter_unit_if.sv - uop types, EBR branch bus and divider request/result interface
package div_iter_pkg;
    localparam int BR_MASK_W = 8;
    localparam int BR_TAG_W  = 3;

    typedef enum logic [2:0] {
        SS_DIV = 3'd0,
        UU_DIV = 3'd1,
        SS_REM = 3'd2,
        UU_REM = 3'd3
    } div_op_e;

    typedef struct packed {
        div_op_e op;
    } ctrl_t;

    typedef struct packed {
        logic [5:0]           rob_idx;
        logic [BR_MASK_W-1:0] branch_mask;
    } meta_t;

    typedef struct packed {
        ctrl_t ctrl;
        meta_t meta;
    } issue_stage_t;
endpackage

interface brb_itf;
    import div_iter_pkg::*;
    logic                broadcast;
    logic [BR_TAG_W-1:0] tag;
    logic                kill;
    logic                clean;

    modport req (input broadcast, tag, kill, clean);
    modport drv (output broadcast, tag, kill, clean);
endinterface

interface div_iter_unit_if #(parameter int WIDTH = 32);
    import div_iter_pkg::*;
    issue_stage_t     istage;
    logic [WIDTH-1:0] div_a;
    logic [WIDTH-1:0] div_b;
    logic             ivalid;
    logic             iready;
    issue_stage_t     ostage;
    logic [WIDTH-1:0] oresult;
    logic             ovalid;
    logic             oready;

    modport master (output istage, div_a, div_b, ivalid, oready,
                    input  iready, ostage, oresult, ovalid);
    modport slave  (input  istage, div_a, div_b, ivalid, oready,
                    output iready, ostage, oresult, ovalid);
endinterface

// File: rtl/div_iter_unit.sv
// rtl/div_iter_unit.sv - shared iterative divider for RISC-V div/divu/rem/remu
// Optional early-out for divide-by-zero, signed overflow and |a|<|b| under DIV_FAST_PATH_EN.
module div_iter_unit
    import div_iter_pkg::*;
#(
    parameter int WIDTH        = 32,
    parameter int BITS_PER_CYC = 1
) (
    input  logic            clk,
    input  logic            rst,
    brb_itf.req             brif,
    div_iter_unit_if.slave  dif
);
    localparam int N  = WIDTH / BITS_PER_CYC;
    localparam int CW = $clog2(N);
    localparam logic [CW-1:0]    CNT_INIT = CW'(N - 1);
    localparam logic [WIDTH-1:0] MIN_VAL  = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, ITER, FIX, DONE} state_e;

    state_e           state;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] rem_r, quo_r, b_mag;
    logic             a_neg, b_neg, div0_r, ovf_r, fast_r;
    issue_stage_t     ostage_r;
    logic [WIDTH-1:0] oresult_r;
    logic             ovalid_r;

    logic             in_signed, a_neg_in, b_neg_in, div0_in, ovf_in;
    logic [WIDTH-1:0] a_mag_in, b_mag_in;
    logic             in_kill, own_kill, accept;
    logic [BR_MASK_W-1:0] clean_mask;

    always_comb begin
        in_signed = (dif.istage.ctrl.op == SS_DIV) || (dif.istage.ctrl.op == SS_REM);
        a_neg_in  = in_signed & dif.div_a[WIDTH-1];
        b_neg_in  = in_signed & dif.div_b[WIDTH-1];
        a_mag_in  = a_neg_in ? -dif.div_a : dif.div_a;
        b_mag_in  = b_neg_in ? -dif.div_b : dif.div_b;
        div0_in   = (dif.div_b == '0);
        ovf_in    = in_signed & (dif.div_a == MIN_VAL) & (dif.div_b == '1);
        in_kill   = brif.broadcast & brif.kill & dif.istage.meta.branch_mask[brif.tag];
        own_kill  = brif.broadcast & brif.kill & ostage_r.meta.branch_mask[brif.tag];
        accept    = dif.ivalid & dif.iready & ~in_kill;
        clean_mask = '0;
        if (brif.broadcast & brif.clean)
            clean_mask[brif.tag] = 1'b1;
    end

    // Restoring shift-subtract, BITS_PER_CYC quotient bits per cycle.
    logic [WIDTH-1:0] r_w, q_w;
    logic [WIDTH:0]   r_sh, diff;
    always_comb begin
        r_w  = rem_r;
        q_w  = quo_r;
        r_sh = '0;
        diff = '0;
        for (int i = 0; i < BITS_PER_CYC; i++) begin
            r_sh = {r_w, q_w[WIDTH-1]};
            q_w  = {q_w[WIDTH-2:0], 1'b0};
            diff = r_sh - {1'b0, b_mag};
            if (!diff[WIDTH]) begin
                r_w    = diff[WIDTH-1:0];
                q_w[0] = 1'b1;
            end else begin
                r_w = r_sh[WIDTH-1:0];
            end
        end
    end

    logic [WIDTH-1:0] q_fix, r_fix, res_fix;
    always_comb begin
        q_fix = (a_neg ^ b_neg) ? -quo_r : quo_r;
        r_fix = a_neg ? -rem_r : rem_r;
        if (div0_r)
            q_fix = '1;
        if (ovf_r) begin
            q_fix = MIN_VAL;
            r_fix = '0;
        end
        res_fix = ((ostage_r.ctrl.op == SS_REM) || (ostage_r.ctrl.op == UU_REM)) ? r_fix : q_fix;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            rem_r     <= '0;
            quo_r     <= '0;
            b_mag     <= '0;
            a_neg     <= 1'b0;
            b_neg     <= 1'b0;
            div0_r    <= 1'b0;
            ovf_r     <= 1'b0;
            fast_r    <= 1'b0;
            ostage_r  <= '0;
            oresult_r <= '0;
            ovalid_r  <= 1'b0;
        end else begin
            case (state)
                IDLE: if (accept) begin
                    ostage_r <= dif.istage;
                    ostage_r.meta.branch_mask <= dif.istage.meta.branch_mask & ~clean_mask;
                    a_neg  <= a_neg_in;
                    b_neg  <= b_neg_in;
                    b_mag  <= b_mag_in;
                    div0_r <= div0_in;
                    ovf_r  <= ovf_in;
                    state  <= ITER;
`ifdef DIV_FAST_PATH_EN
                    // Trivial ops spend one frozen ITER cycle, giving a fixed 2-cycle latency.
                    if (div0_in || ovf_in || (a_mag_in < b_mag_in)) begin
                        fast_r <= 1'b1;
                        cnt    <= '0;
                        rem_r  <= a_mag_in;
                        quo_r  <= '0;
                    end else begin
                        fast_r <= 1'b0;
                        cnt    <= CNT_INIT;
                        rem_r  <= '0;
                        quo_r  <= a_mag_in;
                    end
`else
                    fast_r <= 1'b0;
                    cnt    <= CNT_INIT;
                    rem_r  <= '0;
                    quo_r  <= a_mag_in;
`endif
                end
                ITER: begin
                    if (!fast_r) begin
                        rem_r <= r_w;
                        quo_r <= q_w;
                    end
                    cnt <= cnt - 1'b1;
                    if (cnt == '0)
                        state <= FIX;
                end
                FIX: begin
                    oresult_r <= res_fix;
                    ovalid_r  <= 1'b1;
                    state     <= DONE;
                end
                DONE: if (ovalid_r && dif.oready) begin
                    ovalid_r <= 1'b0;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase

            // Kill overrides completion and the result handshake.
            if (state != IDLE) begin
                ostage_r.meta.branch_mask <= ostage_r.meta.branch_mask & ~clean_mask;
                if (own_kill) begin
                    state    <= IDLE;
                    ovalid_r <= 1'b0;
                end
            end
        end
    end

    assign dif.iready  = (state == IDLE) & ~rst;
    assign dif.ostage  = ostage_r;
    assign dif.oresult = oresult_r;
    assign dif.ovalid  = ovalid_r;
endmodule

// File: doc/div_iter_unit.md
# div_iter_unit

Parametrised iterative integer divider for the backend functional-unit cluster. It replaces the fixed 32-bit, two-instance sequential divider with a single shared datapath and handles all four RISC-V M divide ops: `ss_div`, `uu_div`, `ss_rem`, `uu_rem`. Width and bits retired per cycle are configurable. Divide-by-zero and signed overflow are produced architecturally correct in-block. It sits between the divide reservation station and the CDB arbiter, and obeys EBR branch kill/clean broadcasts.

## Interface
Parameters:
- `WIDTH`, 32, operand/result width; must be a power of two, ≥ 8.
- `BITS_PER_CYC`, 1, quotient bits retired per iteration (1 or 2); `WIDTH % BITS_PER_CYC == 0`.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `brif`  `brb_itf.req`  -  EBR branch bus (`broadcast`, `tag`, `kill`, `clean`).
- `istage`  in  `issue_stage_t`  issuing uop; `ctrl.op` selects the operation, `meta.branch_mask` carries speculation tags.
- `div_a`, `div_b`  in  `WIDTH`  dividend, divisor.
- `ivalid`  in  1  request valid.
- `iready`  out  1  unit idle and able to accept.
- `ostage`  out  `issue_stage_t`  captured uop, with its branch mask kept current.
- `oresult`  out  `WIDTH`  quotient or remainder, registered.
- `ovalid`  out  1  result valid; held until accepted.
- `oready`  in  1  CDB arbiter accepts the result.

## Operation
- FSM states: `IDLE`, `ITER`, `FIX`, `DONE`.
- `iready = (state == IDLE) & ~rst`.
  - Accept condition: `ivalid & iready` and not killed that cycle.
  - The uop is killed that cycle when `brif.broadcast & brif.kill & istage.meta.branch_mask[brif.tag]`. A killed uop is dropped and the unit stays `IDLE`.
- On accept:
  - Capture `istage` into `ostage`. If a clean broadcast is present on a set bit that cycle, clear that bit in the captured copy.
  - Signed ops: latch operand signs and take magnitudes (two's complement negate when negative).
  - Load the remainder register with 0 and the quotient/shift register with `|a|`.
  - Iteration counter := `WIDTH/BITS_PER_CYC - 1`.
  - Next state is `ITER`.
- `ITER`: restoring shift-subtract, `BITS_PER_CYC` bits per cycle. Go to `FIX` when the counter reaches 0.
- `FIX`:
  - Negate the quotient if the operand signs differ.
  - Negate the remainder if the dividend was negative.
  - Select quotient or remainder per `ctrl.op` into `oresult`; set `ovalid`.
  - Next state is `DONE`.
- Special results (RISC-V spec), applied in `FIX` regardless of the path taken:
  - `b == 0`: quotient = all ones; remainder = `a`.
  - Signed `a == MIN`, `b == -1`: quotient = MIN; remainder = 0.
- `DONE`: hold `oresult`/`ovalid`. On `ovalid & oready` at the edge, clear `ovalid` and return to `IDLE`.
- Every cycle in any non-`IDLE` state, a clean broadcast on a set `ostage.meta.branch_mask[brif.tag]` clears that bit.
- Kill: in any non-`IDLE` state, if `brif.broadcast & brif.kill & ostage.meta.branch_mask[brif.tag]`, then next state is `IDLE` and `ovalid` goes to 0.
  - Kill takes priority over completion and over the `oready` handshake.
  - `oresult` need not be cleared.
- Unknown `ctrl.op`: `oresult` = quotient. This is a don't-care for verification.

## Timing
- Reset values: state `IDLE`, `ovalid` 0, `oresult` 0, `ostage` `'0`, `iready` 0 while `rst` is high.
- Normal latency: request accepted at edge T gives `ovalid` high from T+N+1, where N = `WIDTH/BITS_PER_CYC`.
  - `WIDTH=32`, `BITS_PER_CYC=1`: `ovalid` from T+33.
- Throughput: one op in flight. `iready` re-asserts the cycle after the `oready` handshake; there is no same-cycle back-to-back accept.
- `oready` asserted before `ovalid` has no effect.
- `rst` mid-operation aborts the op with no output.

## Configuration
- `DIV_FAST_PATH_EN` defined:
  - At accept, if `b == 0`, signed overflow, or `|a| < |b|`, skip `ITER` and go directly to `FIX`.
  - For `|a| < |b|`: quotient 0, remainder `a`.
  - `ovalid` from T+2.
- `DIV_FAST_PATH_EN` undefined: every op takes the full N+1 latency, with identical results.

## Test plan
- `uu_div` 100/7, then `uu_rem` → 14, then 2. `ovalid` exactly at T+33 (W=32, B=1). Also run with B=2 → T+17.
- `ss_div` -7/2 → 0xFFFFFFFD; `ss_rem` -7/2 → 0xFFFFFFFF. Signed overflow 0x80000000/-1 → quotient 0x80000000, `ss_rem` → 0.
- Divide by zero: `uu_div` 5/0 → 0xFFFFFFFF, `ss_rem` -5/0 → 0xFFFFFFFB. With `DIV_FAST_PATH_EN`, `ovalid` at T+2; without it, at T+33.
- Backpressure: hold `oready` = 0 for 10 cycles after `ovalid`. `ovalid`, `oresult`, and `ostage` stay stable and `iready` stays 0. One cycle after the handshake, `iready` = 1.
- EBR: issue with mask bit 3 set.
  - Clean tag 3 at cycle 5: `ostage` mask bit 3 reads 0 and the op completes normally.
  - Separately, kill tag 3 mid-`ITER`: `ovalid` never rises and `iready` = 1 the next cycle.
  - Kill on the accept cycle: request not taken.
- Kill coincident with the `ovalid & oready` cycle: kill wins and state returns to `IDLE`. Separately, `rst` mid-`ITER` gives all outputs at reset values the next cycle.
